// File: rtl/act_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency, non-stallable activation core; output FIFO holds results.
// Latency: accept edge to m_valid is CORE_LAT cycles; results leave in acceptance order, bit-exact.
// Backpressure: s_ready drops when in-flight + buffered reaches FIFO_DEPTH; optional stat_count via ACT_STREAM_STATS_EN.
module act_stream_adapter #(
   parameter int M          = 2,
   parameter int N          = 10,
   parameter int WIDTH      = M + N,
   parameter int CORE_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic [WIDTH-1:0] core_x,
   input  logic [WIDTH-1:0] core_f,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef ACT_STREAM_STATS_EN
   ,
   output logic [15:0]      stat_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [CORE_LAT-1:0] vld;
   logic [CW-1:0]       occ;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [WIDTH-1:0]    mem [FIFO_DEPTH];

   logic accept;
   logic pop;
   logic capture;

   // Credit check uses registered occupancy only, so m_ready never reaches s_ready combinationally.
   assign s_ready = (occ < DEPTH_C) & ~rst;
   assign accept  = s_valid & s_ready;
   assign m_valid = (cnt != '0);
   assign pop     = m_valid & m_ready;
   assign capture = vld[CORE_LAT-1];
   assign m_data  = m_valid ? mem[rd_ptr] : '0;

   // Launch accepted samples into the core and track them through its fixed latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_x <= '0;
         vld    <= '0;
      end else begin
         if (accept) begin
            core_x <= s_data;
         end
         vld <= (vld << 1) | CORE_LAT'(accept);
      end
   end

   // Single credit counter covers in-flight and buffered results, so every capture finds a slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

   // FIFO pointers and fill level; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({capture, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: m_data is gated to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (capture) begin
         mem[wr_ptr] <= core_f;
      end
   end

`ifdef ACT_STREAM_STATS_EN
   // Completed-transfer counter, wraps at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_count <= '0;
      end else if (pop) begin
         stat_count <= stat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_act_stream_adapter.sv
// Bench for act_stream_adapter: identity-delay core, table vectors, corner sequences, random model check.
// Latency: core model delays core_x by CORE_LAT-1 registers so core_f is valid at the capture edge.
// Backpressure: exercised by table, hand sequences and random m_ready duty phases.
module tb_act_stream_adapter;

   localparam int W          = 12;
   localparam int CORE_LAT   = 2;
   localparam int FIFO_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic signed [W-1:0] s_data = '0;
   logic signed [W-1:0] core_x;
   logic signed [W-1:0] core_f;
   logic                m_valid;
   logic                m_ready = 1'b0;
   logic signed [W-1:0] m_data;
`ifdef ACT_STREAM_STATS_EN
   logic [15:0]         stat_count;
`endif

   act_stream_adapter #(
      .M(2), .N(10), .WIDTH(W), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .core_x(core_x), .core_f(core_f),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef ACT_STREAM_STATS_EN
      , .stat_count(stat_count)
`endif
   );

   always #5 clk = ~clk;

   // Identity core with CORE_LAT-1 register stages (CORE_LAT=2 here).
   logic signed [W-1:0] core_d;
   always @(posedge clk) core_d <= core_x;
   assign core_f = core_d;

   int n_cmp = 0;
   int n_bad = 0;
   int pops  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs are already set by the caller; step one edge and land 1 time unit after it.
   task automatic tick();
      bit pp;
      pp = m_valid && m_ready;
      @(posedge clk);
      #1;
      if (pp) pops++;
   endtask

   task automatic do_reset(input bit check);
      @(negedge clk);
      rst = 1'b1; s_valid = 1'b1; s_data = 12'sd555; m_ready = 1'b0;
      #1;
      if (check) begin
         chk("rst s_ready", 32'(s_ready), 32'd0);
         chk("rst m_valid", 32'(m_valid), 32'd0);
         chk("rst core_x", 32'(core_x), 32'd0);
         chk("rst m_data", 32'(m_data), 32'd0);
`ifdef ACT_STREAM_STATS_EN
         chk("rst stat_count", 32'(stat_count), 32'd0);
`endif
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0; rst = 1'b0; pops = 0;
      @(posedge clk);
      #1;
      if (check) chk("release s_ready", 32'(s_ready), 32'd1);
   endtask

   // A capture while the FIFO is full and not popping would be an overflow.
   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         if (dut.cnt == FIFO_DEPTH && dut.vld[CORE_LAT-1] && !(m_valid && m_ready)) begin
            n_bad++;
            $display("FAIL fifo_overflow: write with cnt=%0d, required no write when full", dut.cnt);
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic                sv;
      logic signed [W-1:0] sd;
      logic                mr;
      logic                e_sr;
      logic                e_mv;
      logic signed [W-1:0] e_md;
      logic signed [W-1:0] e_cx;
   } vec_t;

   typedef struct {
      logic signed [W-1:0] d;
      int                  rem;
   } fl_t;

   vec_t tbl[13];
   logic signed [W-1:0] got[$];
   logic signed [W-1:0] mq[$];
   fl_t                 fq[$];

   initial begin
      int idx;
      int acc;
      int stale;
      int thresh;
      int occ_m;
      bit a_m;
      bit p_m;
      logic signed [W-1:0] last_x;
      logic signed [W-1:0] exp_md;

      // Single sample then six-sample back-to-back stream, m_ready held high.
      tbl[0]  = '{1'b1, 12'sd1024,  1'b1, 1'b1, 1'b0, 12'sd0,     12'sd1024};
      tbl[1]  = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b0, 12'sd0,     12'sd1024};
      tbl[2]  = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b1, 12'sd1024,  12'sd1024};
      tbl[3]  = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b0, 12'sd0,     12'sd1024};
      tbl[4]  = '{1'b1, 12'sd2047,  1'b1, 1'b1, 1'b0, 12'sd0,     12'sd2047};
      tbl[5]  = '{1'b1, -12'sd2047, 1'b1, 1'b1, 1'b0, 12'sd0,     -12'sd2047};
      tbl[6]  = '{1'b1, 12'sd1024,  1'b1, 1'b1, 1'b1, 12'sd2047,  12'sd1024};
      tbl[7]  = '{1'b1, -12'sd1024, 1'b1, 1'b1, 1'b1, -12'sd2047, -12'sd1024};
      tbl[8]  = '{1'b1, 12'sd16,    1'b1, 1'b1, 1'b1, 12'sd1024,  12'sd16};
      tbl[9]  = '{1'b1, -12'sd16,   1'b1, 1'b1, 1'b1, -12'sd1024, -12'sd16};
      tbl[10] = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b1, 12'sd16,    -12'sd16};
      tbl[11] = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b1, -12'sd16,   -12'sd16};
      tbl[12] = '{1'b0, 12'sd0,     1'b1, 1'b1, 1'b0, 12'sd0,     -12'sd16};

      do_reset(1'b1);

      for (int i = 0; i < 13; i++) begin
         s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
         tick();
         chk($sformatf("tbl%0d s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
         chk($sformatf("tbl%0d m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
         chk($sformatf("tbl%0d m_data", i),  32'(m_data),  32'(tbl[i].e_md));
         chk($sformatf("tbl%0d core_x", i),  32'(core_x),  32'(tbl[i].e_cx));
      end
`ifdef ACT_STREAM_STATS_EN
      chk("stat after stream", 32'(stat_count), 32'(pops & 32'hFFFF));
`endif

      // Backpressure: offer 1..6 with m_ready low; only FIFO_DEPTH get in.
      m_ready = 1'b0; idx = 1; acc = 0;
      for (int c = 0; c < 8; c++) begin
         s_valid = (idx <= 6); s_data = W'(idx);
         if (s_valid && s_ready) begin acc++; idx++; end
         tick();
      end
      chk("bp accepted", 32'(acc), 32'd4);
      chk("bp s_ready low", 32'(s_ready), 32'd0);
      chk("bp head", 32'(m_data), 32'sd1);
      m_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 24 && got.size() < 6; c++) begin
         s_valid = (idx <= 6); s_data = W'(idx);
         if (s_valid && s_ready) idx++;
         if (m_valid && m_ready) got.push_back(m_data);
         tick();
         if (c == 0) chk("bp reopen", 32'(s_ready), 32'd1);
      end
      s_valid = 1'b0;
      chk("bp out count", 32'(got.size()), 32'd6);
      for (int i = 0; i < got.size(); i++) chk($sformatf("bp out%0d", i), 32'(got[i]), 32'(i + 1));

      // Mid-operation reset with two in flight and one buffered.
      m_ready = 1'b0; s_valid = 1'b1;
      s_data = 12'sd100; tick();
      s_data = 12'sd200; tick();
      s_data = 12'sd300; tick();
      s_valid = 1'b0;
      chk("mid pre m_valid", 32'(m_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid rst m_valid", 32'(m_valid), 32'd0);
      chk("mid rst s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; m_ready = 1'b1; pops = 0;
      @(posedge clk); #1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         if (m_valid) stale++;
         tick();
      end
      chk("mid no stale", 32'(stale), 32'd0);

      // Random traffic against a queue-based reference.
      do_reset(1'b0);
      mq.delete(); fq.delete(); last_x = '0;
      for (int c = 0; c < 2000; c++) begin
         occ_m  = fq.size() + mq.size();
         exp_md = (mq.size() != 0) ? mq[0] : '0;
         chk("rnd s_ready", 32'(s_ready), 32'(occ_m < FIFO_DEPTH));
         chk("rnd m_valid", 32'(m_valid), 32'(mq.size() != 0));
         chk("rnd m_data", 32'(m_data), 32'(exp_md));
         chk("rnd core_x", 32'(core_x), 32'(last_x));
         thresh  = ((c / 250) % 4) * 30 + 5;
         s_valid = ($urandom_range(0, 99) < 70);
         s_data  = W'($urandom);
         m_ready = ($urandom_range(0, 99) < thresh);
         a_m = s_valid && (occ_m < FIFO_DEPTH);
         p_m = (mq.size() != 0) && m_ready;
         tick();
         if (p_m) void'(mq.pop_front());
         for (int k = 0; k < fq.size(); k++) fq[k].rem = fq[k].rem - 1;
         while (fq.size() != 0 && fq[0].rem == 0) mq.push_back(fq.pop_front().d);
         if (a_m) begin
            fq.push_back('{s_data, CORE_LAT});
            last_x = s_data;
         end
      end
      s_valid = 1'b0;

`ifdef ACT_STREAM_STATS_EN
      // Counter wrap: run pops up to 65535, then one more.
      do_reset(1'b0);
      s_valid = 1'b1; m_ready = 1'b1; s_data = 12'sd7;
      for (int c = 0; c < 70000 && pops < 65535; c++) tick();
      chk("stat pops reached", 32'(pops), 32'd65535);
      chk("stat 65535", 32'(stat_count), 32'd65535);
      chk("stat pre-wrap m_valid", 32'(m_valid), 32'd1);
      tick();
      chk("stat wrap", 32'(stat_count), 32'd0);
      s_valid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
